// File: rtl/sram_arb_pkg.sv
// Shared state encoding, port indices and counter width for the two-port SRAM arbiter.
package sram_arb_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WRITE    = 3'd1,
        RD_ISSUE = 3'd2,
        RD_DATA  = 3'd3,
        TURN     = 3'd4
    } state_e;

    localparam int P0     = 0;
    localparam int P1     = 1;
    localparam int PERF_W = 16;

    function automatic logic [1:0] port_onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the port that wins a tie and
// moves to the non-winning port after every grant.
module rr_arb2 (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_req,
    input  logic       i_en,
    output logic [1:0] o_gnt,
    output logic       o_ptr
);

    logic r_ptr;

    always_comb begin
        o_gnt = 2'b00;
        if (i_en) begin
            case (i_req)
                2'b01:   o_gnt = 2'b01;
                2'b10:   o_gnt = 2'b10;
                2'b11:   o_gnt = r_ptr ? 2'b10 : 2'b01;
                default: o_gnt = 2'b00;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= 1'b0;
        end else if (i_en && |o_gnt) begin
            r_ptr <= o_gnt[0];
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/sram_arb_ctrl.sv
// Two-requester SRAM controller: round-robin grant, write / two-phase read sequencing, turnaround.
// Define SRAM_ARB_PERF_EN to add saturating grant and stall counters.
module sram_arb_ctrl
    import sram_arb_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [1:0]        req_valid_i,
    output logic [1:0]        req_ready_o,
    input  logic [1:0]        req_we_i,
    input  logic [2*AW-1:0]   req_addr_i,
    input  logic [2*DW-1:0]   req_wdata_i,
    output logic [1:0]        rsp_valid_o,
    output logic [DW-1:0]     rsp_rdata_o,
    output logic              sram_cs_n_o,
    output logic              sram_oe_n_o,
    output logic              sram_we_n_o,
    output logic [AW-1:0]     sram_addr_o,
    inout  wire  [DW-1:0]     sram_data_io
`ifdef SRAM_ARB_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_grant0_o,
    output logic [PERF_W-1:0] perf_grant1_o,
    output logic [PERF_W-1:0] perf_stall_o
`endif
);

    state_e          r_state;
    state_e          w_state_nxt;
    logic [1:0]      w_gnt;
    logic            w_en;
    logic            w_sel;
    logic            w_unused_ptr;
    logic            r_id;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_wdata;
    logic            r_cs_n;
    logic            r_oe_n;
    logic            r_we_n;
    logic            r_drive;
    logic [1:0]      r_rsp_valid;
    logic [DW-1:0]   r_rdata;

    // Grants are suppressed while reset is held so ready stays low in reset.
    assign w_en  = rst_ni && (r_state == IDLE);
    assign w_sel = w_gnt[1];

    rr_arb2 u_arb (
        .i_clk   (clk_i),
        .i_rst_n (rst_ni),
        .i_req   (req_valid_i),
        .i_en    (w_en),
        .o_gnt   (w_gnt),
        .o_ptr   (w_unused_ptr)
    );

    assign req_ready_o = w_gnt;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:     if (|w_gnt) w_state_nxt = req_we_i[w_sel] ? WRITE : RD_ISSUE;
            WRITE:    w_state_nxt = IDLE;
            RD_ISSUE: w_state_nxt = RD_DATA;
            RD_DATA:  w_state_nxt = TURN;
            TURN:     w_state_nxt = IDLE;
            default:  w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_id    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (|w_gnt) begin
                r_id    <= w_sel;
                r_addr  <= w_sel ? req_addr_i[AW +: AW]  : req_addr_i[0 +: AW];
                r_wdata <= w_sel ? req_wdata_i[DW +: DW] : req_wdata_i[0 +: DW];
            end
        end
    end

    // Pins are decoded from the next state so they change exactly on state entry.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cs_n      <= 1'b1;
            r_oe_n      <= 1'b1;
            r_we_n      <= 1'b1;
            r_drive     <= 1'b0;
            r_rsp_valid <= 2'b00;
            r_rdata     <= '0;
        end else begin
            r_cs_n      <= !(w_state_nxt inside {WRITE, RD_ISSUE, RD_DATA});
            r_oe_n      <= !(w_state_nxt inside {RD_ISSUE, RD_DATA});
            r_we_n      <= (w_state_nxt != WRITE);
            r_drive     <= (w_state_nxt == WRITE);
            r_rsp_valid <= (w_state_nxt == TURN) ? port_onehot(r_id) : 2'b00;
            if (r_state == RD_DATA) r_rdata <= sram_data_io;
        end
    end

    assign sram_cs_n_o  = r_cs_n;
    assign sram_oe_n_o  = r_oe_n;
    assign sram_we_n_o  = r_we_n;
    assign sram_addr_o  = r_addr;
    assign sram_data_io = r_drive ? r_wdata : {DW{1'bz}};
    assign rsp_valid_o  = r_rsp_valid;
    assign rsp_rdata_o  = r_rdata;

`ifdef SRAM_ARB_PERF_EN
    logic [PERF_W-1:0] r_perf_g0;
    logic [PERF_W-1:0] r_perf_g1;
    logic [PERF_W-1:0] r_perf_stall;
    logic              w_stall;

    assign w_stall = |(req_valid_i & ~w_gnt);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_perf_g0    <= '0;
            r_perf_g1    <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_gnt[P0] && (r_perf_g0 != '1))  r_perf_g0    <= r_perf_g0 + 1'b1;
            if (w_gnt[P1] && (r_perf_g1 != '1))  r_perf_g1    <= r_perf_g1 + 1'b1;
            if (w_stall && (r_perf_stall != '1)) r_perf_stall <= r_perf_stall + 1'b1;
        end
    end

    assign perf_grant0_o = r_perf_g0;
    assign perf_grant1_o = r_perf_g1;
    assign perf_stall_o  = r_perf_stall;
`endif

endmodule

// File: tb/tb_sram_arb_ctrl.sv
// Bench for sram_arb_ctrl: SRAM model with registered read, vector table, corner sequences,
// and random traffic checked against a transaction-level model.
module tb_sram_arb_ctrl;

    localparam int DW = 8;
    localparam int AW = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [1:0]      req_valid;
    logic [1:0]      ready;
    logic [1:0]      req_we;
    logic [2*AW-1:0] req_addr;
    logic [2*DW-1:0] req_wdata;
    logic [1:0]      rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            cs_n, oe_n, we_n;
    logic [AW-1:0]   addr;
    wire  [DW-1:0]   sram_data;
    logic [2:0]      pins;
    logic [15:0]     perf_g0, perf_g1, perf_stall;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    sram_arb_ctrl #(.DW(DW), .AW(AW)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (ready),
        .req_we_i     (req_we),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .rsp_valid_o  (rsp_valid),
        .rsp_rdata_o  (rsp_rdata),
        .sram_cs_n_o  (cs_n),
        .sram_oe_n_o  (oe_n),
        .sram_we_n_o  (we_n),
        .sram_addr_o  (addr),
        .sram_data_io (sram_data)
`ifdef SRAM_ARB_PERF_EN
        ,
        .perf_grant0_o (perf_g0),
        .perf_grant1_o (perf_g1),
        .perf_stall_o  (perf_stall)
`endif
    );

`ifndef SRAM_ARB_PERF_EN
    assign perf_g0 = '0;
    assign perf_g1 = '0;
    assign perf_stall = '0;
`endif

    assign pins = {cs_n, oe_n, we_n};

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- SRAM model: power-on pattern reloaded while reset held ----------------
    function automatic logic [7:0] init_val(input int a);
        return 8'(a * 29 + 17);
    endfunction

    logic [DW-1:0] sram_mem [16];
    logic [DW-1:0] sram_q;
    logic          sram_qv = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int a = 0; a < 16; a++) sram_mem[a] <= init_val(a);
        end else if (!cs_n && !we_n) begin
            sram_mem[addr] <= sram_data;
        end
        if (!cs_n && !oe_n && we_n) sram_q <= sram_mem[addr];
        sram_qv <= !cs_n && !oe_n && we_n;
    end
    assign sram_data = (!cs_n && !oe_n && we_n && sram_qv) ? sram_q : {DW{1'bz}};

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit bus_idle();
        return $isunknown(sram_data) || (sram_data == '0);
    endfunction

    task automatic drive(input int k, input bit v, input bit we, input logic [3:0] a, input logic [7:0] d);
        req_valid[k]          = v;
        req_we[k]             = we;
        req_addr[k*AW +: AW]  = a;
        req_wdata[k*DW +: DW] = d;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = 2'b00;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [1:0] valid;
        logic [1:0] we;
        logic [1:0] exp_ready;
        logic [2:0] exp_pins;
    } vec_t;
    vec_t vecs [9];

    // ---------------- reference model state ----------------
    typedef struct {
        int         cyc;
        logic       port;
        logic [7:0] data;
    } rsp_t;
    rsp_t        exp_q [$];
    logic [7:0]  model_mem [16];
    int          next_acc, last_start, last_kind;
    logic        mptr;
    logic [3:0]  last_addr;
    logic [7:0]  last_wdata;
    logic [1:0]  acc, pend, pg;
    int          g0, g1, stl;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{2'b11, 2'b11, 2'b01, 3'b010};
        vecs[1] = '{2'b11, 2'b00, 2'b10, 3'b001};
        vecs[2] = '{2'b10, 2'b10, 2'b10, 3'b010};
        vecs[3] = '{2'b11, 2'b01, 2'b01, 3'b010};
        vecs[4] = '{2'b01, 2'b00, 2'b01, 3'b001};
        vecs[5] = '{2'b11, 2'b10, 2'b10, 3'b010};
        vecs[6] = '{2'b00, 2'b00, 2'b00, 3'b111};
        vecs[7] = '{2'b01, 2'b01, 2'b01, 3'b010};
        vecs[8] = '{2'b11, 2'b00, 2'b10, 3'b001};

        req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0;

        // Reset state, with both ports already requesting reads of 0x1 / 0x2.
        drive(0, 1, 0, 4'h1, 8'h00);
        drive(1, 1, 0, 4'h2, 8'h00);
        @(negedge clk);
        chk("RST_pins", pins, 3'b111);
        chk("RST_ready", ready, 2'b00);
        chk("RST_rsp", rsp_valid, 2'b00);
        chk("RST_rdata", rsp_rdata, 8'h00);
        chk("RST_addr", addr, 4'h0);
        chk("RST_bus_idle", bus_idle(), 1);
        @(posedge clk); #1 rst_n = 1'b1;

        // B: p0 first, p1 at the next IDLE, responses in order.
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            chk("B_ready", ready, i == 0 ? 2'b01 : (i == 4 ? 2'b10 : 2'b00));
            chk("B_rsp", rsp_valid, i == 3 ? 2'b01 : (i == 7 ? 2'b10 : 2'b00));
            if (i == 3) chk("B_data0", rsp_rdata, init_val(1));
            if (i == 7) chk("B_data1", rsp_rdata, init_val(2));
            @(posedge clk); #1;
            if (i == 0) req_valid[0] = 1'b0;
            if (i == 4) req_valid[1] = 1'b0;
        end

        // A: write 0xA5 to 0x3 then read it back on port 0.
        drive(0, 1, 1, 4'h3, 8'hA5);
        @(negedge clk); chk("A_wr_ready", ready, 2'b01);
        @(posedge clk); #1 req_valid = 2'b00;
        @(negedge clk);
        chk("A_wr_pins", pins, 3'b010);
        chk("A_wr_bus", sram_data, 8'hA5);
        chk("A_wr_addr", addr, 4'h3);
        @(posedge clk); #1 drive(0, 1, 0, 4'h3, 8'h00);
        @(negedge clk); chk("A_rd_ready", ready, 2'b01);
        @(posedge clk); #1 req_valid = 2'b00;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            chk("A_rd_rsp", rsp_valid, i == 3 ? 2'b01 : 2'b00);
            if (i == 3) chk("A_rd_data", rsp_rdata, 8'hA5);
            @(posedge clk); #1;
        end

        // C: both ports stream writes; one grant every 2 cycles, alternating from p1.
        drive(0, 1, 1, 4'h4, 8'h44);
        drive(1, 1, 1, 4'h5, 8'h55);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("C_alt", ready, (i % 2 == 0) ? (((i / 2) % 2 == 0) ? 2'b10 : 2'b01) : 2'b00);
            if (i % 2 == 1) chk("C_wr_bus", sram_data, ((i / 2) % 2 == 0) ? 8'h55 : 8'h44);
            @(posedge clk); #1;
        end
        req_valid = 2'b00;

        // D: read of 0x4 with a write pending behind it; TURN must be fully released.
        drive(0, 1, 0, 4'h4, 8'h5A);
        for (int i = 0; i <= 5; i++) begin
            @(negedge clk);
            chk("D_ready", ready, i == 0 ? 2'b01 : (i == 4 ? 2'b10 : 2'b00));
            if (i == 3) begin
                chk("D_turn_pins", pins, 3'b111);
                chk("D_turn_bus_idle", bus_idle(), 1);
                chk("D_rsp", rsp_valid, 2'b01);
                chk("D_data", rsp_rdata, 8'h44);
            end
            if (i == 5) begin
                chk("D_wr_pins", pins, 3'b010);
                chk("D_wr_bus", sram_data, 8'h3C);
            end
            @(posedge clk); #1;
            if (i == 0) begin req_valid[0] = 1'b0; drive(1, 1, 1, 4'h6, 8'h3C); end
            if (i == 4) req_valid[1] = 1'b0;
        end

        // E: reset asserted during RD_DATA of a p0 read.
        drive(0, 1, 0, 4'h6, 8'h00);
        @(negedge clk); chk("E_ready", ready, 2'b01);
        @(posedge clk); #1 req_valid = 2'b00;
        @(posedge clk); #2;
        chk("E_pre_pins", pins, 3'b001);
        rst_n = 1'b0;
        #1;
        chk("E_async_pins", pins, 3'b111);
        chk("E_async_rsp", rsp_valid, 2'b00);
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("E_no_rsp", rsp_valid, 2'b00);
            chk("E_idle_pins", pins, 3'b111);
            @(posedge clk); #1;
        end
        drive(0, 1, 1, 4'h7, 8'h77);
        drive(1, 1, 0, 4'h6, 8'h00);
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            chk("E_ready_after", ready, i == 0 ? 2'b01 : (i == 2 ? 2'b10 : 2'b00));
            if (i == 1) begin
                chk("E_wr_pins", pins, 3'b010);
                chk("E_wr_bus", sram_data, 8'h77);
            end
            chk("E_rsp_after", rsp_valid, i == 5 ? 2'b10 : 2'b00);
            if (i == 5) chk("E_rd_data", rsp_rdata, init_val(6));
            @(posedge clk); #1;
            if (i == 0) req_valid[0] = 1'b0;
            if (i == 2) req_valid[1] = 1'b0;
        end

        // Table: single-cycle requests from IDLE, arbitration and first-cycle pins.
        do_reset();
        for (int v = 0; v < 9; v++) begin
            req_valid = vecs[v].valid;
            req_we    = vecs[v].we;
            req_addr  = {4'h9, 4'h8};
            req_wdata = {8'hB1, 8'hA0};
            @(negedge clk); chk("T_ready", ready, vecs[v].exp_ready);
            @(posedge clk); #1 req_valid = 2'b00;
            @(negedge clk); chk("T_pins", pins, vecs[v].exp_pins);
            repeat (4) @(posedge clk);
            #1;
        end

        // Random traffic against the transaction-level model.
        do_reset();
        for (int a = 0; a < 16; a++) model_mem[a] = init_val(a);
        next_acc = 0; mptr = 1'b0; last_kind = 0; last_start = 0;
        last_addr = '0; last_wdata = '0; acc = 2'b00; pend = 2'b00;
        exp_q.delete();
        for (int n = 0; n < 800; n++) begin
            for (int k = 0; k < 2; k++) begin
                bit wd;
                wd = 1'b0;
                if (acc[k]) pend[k] = 1'b0;
                else if (pend[k] && $urandom_range(15) == 0) begin pend[k] = 1'b0; wd = 1'b1; end
                if (!pend[k] && !wd && n < 780 && $urandom_range(1) == 1) begin
                    pend[k] = 1'b1;
                    drive(k, 1, 1'($urandom_range(1)), 4'($urandom_range(15)), 8'($urandom_range(255)));
                end
                req_valid[k] = pend[k];
            end
            @(negedge clk);
            if (last_kind == 1 && cyc == last_start + 1) begin
                chk("R_wr_pins", pins, 3'b010);
                chk("R_wr_addr", addr, last_addr);
                chk("R_wr_bus", sram_data, last_wdata);
            end else if (last_kind == 2 && (cyc == last_start + 1 || cyc == last_start + 2)) begin
                chk("R_rd_pins", pins, 3'b001);
                chk("R_rd_addr", addr, last_addr);
            end else begin
                chk("R_idle_pins", pins, 3'b111);
                chk("R_bus_idle", bus_idle(), 1);
            end
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                chk("R_rsp", rsp_valid, exp_q[0].port ? 2'b10 : 2'b01);
                chk("R_rdata", rsp_rdata, exp_q[0].data);
                void'(exp_q.pop_front());
            end else begin
                chk("R_rsp_none", rsp_valid, 2'b00);
            end
            pg = 2'b00;
            if (cyc >= next_acc) begin
                if (req_valid == 2'b01)      pg = 2'b01;
                else if (req_valid == 2'b10) pg = 2'b10;
                else if (req_valid == 2'b11) pg = mptr ? 2'b10 : 2'b01;
            end
            chk("R_ready", ready, pg);
            acc = pg;
            if (pg != 2'b00) begin
                int w;
                w = pg[1] ? 1 : 0;
                mptr       = (w == 0);
                last_addr  = req_addr[w*AW +: AW];
                last_wdata = req_wdata[w*DW +: DW];
                last_start = cyc;
                if (req_we[w]) begin
                    last_kind = 1;
                    model_mem[last_addr] = last_wdata;
                    next_acc = cyc + 2;
                end else begin
                    last_kind = 2;
                    exp_q.push_back('{cyc + 3, pg[1], model_mem[last_addr]});
                    next_acc = cyc + 4;
                end
            end
            @(posedge clk); #1;
        end
        req_valid = 2'b00;
        chk("R_drain", exp_q.size(), 0);

`ifdef SRAM_ARB_PERF_EN
        // Perf: 4 solo p0 grants, then 12 contended grants alternating from p1.
        do_reset();
        g0 = 0; g1 = 0; stl = 0;
        drive(0, 1, 1, 4'hA, 8'h10);
        drive(1, 0, 1, 4'hB, 8'h20);
        for (int n = 0; n < 200 && (g0 + g1) < 16; n++) begin
            if (g0 >= 4) req_valid[1] = 1'b1;
            @(negedge clk);
            if (ready[0]) g0++;
            if (ready[1]) g1++;
            if (|(req_valid & ~ready)) stl++;
            @(posedge clk); #1;
        end
        req_valid = 2'b00;
        @(negedge clk);
        chk("P_grant0", perf_g0, 16'd10);
        chk("P_grant1", perf_g1, 16'd6);
        chk("P_stall", perf_stall, stl);
        @(posedge clk); #1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
